// File: rtl/generic_bus_arbiter.sv
// N-master to 1-slave generic bus arbiter with registered grant,
// round-robin or fixed-priority selection and an optional access watchdog.
module generic_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int BE_W  = DATA_WIDTH / 8
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_MASTERS-1:0]            m_ren,
    input  logic [NUM_MASTERS-1:0]            m_wen,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS*BE_W-1:0]       m_byte_en,
    output logic [NUM_MASTERS-1:0]            m_busy,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic                              s_ren,
    output logic                              s_wen,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    output logic [BE_W-1:0]                   s_byte_en,
    input  logic                              s_busy,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    output logic                              grant_valid,
    output logic [IDX_W-1:0]                  grant_idx
);

    // Per-master views padded to a power of two so grant_idx indexes safely.
    localparam int NSLOT = 1 << IDX_W;
    localparam logic [15:0] LP_TO_LAST =
        (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;
    localparam logic LP_WDOG_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [15:0]      r_wdog;

    logic [NUM_MASTERS-1:0] w_req;
    logic                   w_any_req;
    logic [IDX_W-1:0]       w_winner;
    logic [NUM_MASTERS-1:0] w_gsel;

    logic [NSLOT-1:0]      w_ren_v;
    logic [NSLOT-1:0]      w_wen_v;
    logic [ADDR_WIDTH-1:0] w_addr  [NSLOT];
    logic [DATA_WIDTH-1:0] w_wdata [NSLOT];
    logic [BE_W-1:0]       w_be    [NSLOT];

    logic w_g_ren;
    logic w_g_wen;
    logic w_g_req;
    logic w_done;
    logic w_timeout;

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        if (g < NUM_MASTERS) begin : g_real
            assign w_ren_v[g] = m_ren[g];
            assign w_wen_v[g] = m_wen[g];
            assign w_addr[g]  = m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[g] = m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
            assign w_be[g]    = m_byte_en[g*BE_W +: BE_W];
        end else begin : g_pad
            assign w_ren_v[g] = 1'b0;
            assign w_wen_v[g] = 1'b0;
            assign w_addr[g]  = '0;
            assign w_wdata[g] = '0;
            assign w_be[g]    = '0;
        end
    end

    function automatic logic [IDX_W-1:0] pick_rr(
        input logic [NUM_MASTERS-1:0] req,
        input logic [IDX_W-1:0]       ptr
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               j;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
            if (!found && req[j]) begin
                pick  = IDX_W'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] pick_low(
        input logic [NUM_MASTERS-1:0] req
    );
        logic [IDX_W-1:0] pick;
        pick = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) pick = IDX_W'(i);
        end
        return pick;
    endfunction

    assign w_req     = m_ren | m_wen;
    assign w_any_req = |w_req;
    assign w_winner  = (ARB_MODE == 1) ? pick_low(w_req)
                                       : pick_rr(w_req, r_rr_ptr);

    always_comb begin
        w_gsel = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_gsel[i] = (r_grant_idx == IDX_W'(i));
        end
    end

    assign w_g_ren   = w_ren_v[r_grant_idx];
    assign w_g_wen   = w_wen_v[r_grant_idx];
    assign w_g_req   = w_g_ren | w_g_wen;
    assign w_done    = w_g_req & ~s_busy;
    assign w_timeout = LP_WDOG_EN & w_g_req & s_busy
                     & (r_wdog == LP_TO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        s_ren       = 1'b0;
        s_wen       = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_byte_en   = '0;
        m_busy      = '1;
        m_err       = '0;
        m_rdata     = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) w_state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                s_addr    = w_addr[r_grant_idx];
                s_wdata   = w_wdata[r_grant_idx];
                s_byte_en = w_be[r_grant_idx];
                // A timed-out access is pulled off the slave and errored back.
                if (w_timeout) begin
                    m_busy      = ~w_gsel;
                    m_err       = w_gsel;
                    w_state_nxt = ST_IDLE;
                end else begin
                    s_ren = w_g_ren;
                    s_wen = w_g_wen;
                    if (w_done) begin
                        m_busy      = ~w_gsel;
                        m_rdata     = s_rdata;
                        w_state_nxt = ST_IDLE;
                    end else if (!w_g_req) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= IDX_W'(NUM_MASTERS - 1);
            r_wdog      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any_req) begin
                r_grant_idx <= w_winner;
                r_wdog      <= '0;
                if (ARB_MODE == 0) r_rr_ptr <= w_winner;
            end else if (r_state == ST_GRANT && s_busy) begin
                r_wdog <= r_wdog + 16'd1;
            end
        end
    end

    assign grant_valid = (r_state == ST_GRANT);
    assign grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Scoreboard bench for generic_bus_arbiter: round-robin/watchdog instance
// plus a fixed-priority instance, driven with directed vectors.
module tb_generic_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int IW = 2;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic [N-1:0]    a_ren, a_wen, a_busy, a_err;
    logic [N*AW-1:0] a_addr;
    logic [N*DW-1:0] a_wdata;
    logic [N*BW-1:0] a_be;
    logic [DW-1:0]   a_rdata, a_swdata, a_srdata;
    logic [AW-1:0]   a_saddr;
    logic [BW-1:0]   a_sbe;
    logic            a_sren, a_swen, a_sbusy, a_gv;
    logic [IW-1:0]   a_gi;

    logic [N-1:0]    b_ren, b_wen, b_busy, b_err;
    logic [N*AW-1:0] b_addr;
    logic [N*DW-1:0] b_wdata;
    logic [N*BW-1:0] b_be;
    logic [DW-1:0]   b_rdata, b_swdata, b_srdata;
    logic [AW-1:0]   b_saddr;
    logic [BW-1:0]   b_sbe;
    logic            b_sren, b_swen, b_sbusy, b_gv;
    logic [IW-1:0]   b_gi;

    generic_bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .ARB_MODE(0), .TIMEOUT_CYCLES(4)
    ) u_rr (
        .CLK(CLK), .RST(RST),
        .m_ren(a_ren), .m_wen(a_wen), .m_addr(a_addr),
        .m_wdata(a_wdata), .m_byte_en(a_be),
        .m_busy(a_busy), .m_rdata(a_rdata), .m_err(a_err),
        .s_ren(a_sren), .s_wen(a_swen), .s_addr(a_saddr),
        .s_wdata(a_swdata), .s_byte_en(a_sbe),
        .s_busy(a_sbusy), .s_rdata(a_srdata),
        .grant_valid(a_gv), .grant_idx(a_gi)
    );

    generic_bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .ARB_MODE(1), .TIMEOUT_CYCLES(0)
    ) u_fp (
        .CLK(CLK), .RST(RST),
        .m_ren(b_ren), .m_wen(b_wen), .m_addr(b_addr),
        .m_wdata(b_wdata), .m_byte_en(b_be),
        .m_busy(b_busy), .m_rdata(b_rdata), .m_err(b_err),
        .s_ren(b_sren), .s_wen(b_swen), .s_addr(b_saddr),
        .s_wdata(b_swdata), .s_byte_en(b_sbe),
        .s_busy(b_sbusy), .s_rdata(b_srdata),
        .grant_valid(b_gv), .grant_idx(b_gi)
    );

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic err,
                            input logic [31:0] rd);
        exp_t t;
        t.idx   = idx;
        t.err   = err;
        t.rdata = rd;
        sb.push_back(t);
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    // Monitor: any completion or error pulse must match the queue head.
    always @(negedge CLK) begin
        exp_t        e;
        logic [2:0]  eb;
        logic [2:0]  ee;
        if ((~a_busy) != 3'b000 || a_err != 3'b000) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: busy=%b err=%b expected none",
                         a_busy, a_err);
            end else begin
                e  = sb.pop_front();
                eb = ~(3'b001 << e.idx);
                ee = e.err ? (3'b001 << e.idx) : 3'b000;
                chk("resp_busy", 32'(a_busy), 32'(eb));
                chk("resp_err", 32'(a_err), 32'(ee));
                chk("resp_rdata", a_rdata, e.rdata);
            end
        end
    end

    initial begin
        RST = 1'b1;
        a_ren = '0; a_wen = '0; a_addr = '0; a_wdata = '0; a_be = '0;
        a_sbusy = 1'b0; a_srdata = '0;
        b_ren = '0; b_wen = '0; b_addr = '0; b_wdata = '0; b_be = '0;
        b_sbusy = 1'b0; b_srdata = '0;
        nxt();
        nxt();
        RST = 1'b0;
        smp();
        chk("rst_busy", 32'(a_busy), 32'h7);
        chk("rst_err", 32'(a_err), 32'h0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_sren", 32'(a_sren), 32'h0);
        chk("rst_swen", 32'(a_swen), 32'h0);
        chk("rst_saddr", a_saddr, 32'h0);
        chk("rst_swdata", a_swdata, 32'h0);
        chk("rst_sbe", 32'(a_sbe), 32'h0);
        chk("rst_gv", 32'(a_gv), 32'h0);
        chk("rst_gi", 32'(a_gi), 32'h0);
        chk("rst_fp_busy", 32'(b_busy), 32'h7);
        nxt();

        // Single read, slave answers at once
        a_ren[0] = 1'b1;
        a_addr[0 +: AW] = 32'h8000_0000;
        a_sbusy = 1'b0;
        a_srdata = 32'hDEAD_BEEF;
        smp();
        chk("rd_c0_gv", 32'(a_gv), 32'h0);
        nxt();
        push_exp(0, 1'b0, 32'hDEAD_BEEF);
        smp();
        chk("rd_c1_sren", 32'(a_sren), 32'h1);
        chk("rd_c1_saddr", a_saddr, 32'h8000_0000);
        chk("rd_c1_gi", 32'(a_gi), 32'h0);
        chk("rd_c1_gv", 32'(a_gv), 32'h1);
        nxt();
        a_ren = '0;
        smp();
        chk("rd_c2_idle", 32'(a_gv), 32'h0);
        nxt();

        // Round-robin, all masters requesting; reset restores rr_ptr
        RST = 1'b1;
        nxt();
        RST = 1'b0;
        a_ren = 3'b111;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk($sformatf("rr_idle_gv%0d", k), 32'(a_gv), 32'h0);
            nxt();
            a_srdata = 32'hA0 + k;
            push_exp(k % 3, 1'b0, 32'hA0 + k);
            smp();
            chk($sformatf("rr_gv%0d", k), 32'(a_gv), 32'h1);
            chk($sformatf("rr_gi%0d", k), 32'(a_gi), 32'(k % 3));
            nxt();
        end
        a_ren = '0;
        smp();
        chk("rr_end_idle", 32'(a_gv), 32'h0);
        nxt();

        // Watchdog expiry on master 2
        a_ren[2] = 1'b1;
        a_addr[2*AW +: AW] = 32'h0000_2000;
        a_sbusy = 1'b1;
        a_srdata = 32'h5555_5555;
        smp();
        nxt();
        for (int c = 1; c <= 3; c++) begin
            smp();
            chk($sformatf("wd_sren_c%0d", c), 32'(a_sren), 32'h1);
            nxt();
        end
        push_exp(2, 1'b1, 32'h0);
        smp();
        chk("wd_to_sren", 32'(a_sren), 32'h0);
        chk("wd_to_gv", 32'(a_gv), 32'h1);
        nxt();
        a_ren = '0;
        smp();
        chk("wd_to_idle", 32'(a_gv), 32'h0);
        nxt();

        // Slave finishes on the would-be timeout cycle
        a_ren[2] = 1'b1;
        smp();
        nxt();
        for (int c = 1; c <= 3; c++) begin
            smp();
            nxt();
        end
        a_sbusy = 1'b0;
        a_srdata = 32'h600D_F00D;
        push_exp(2, 1'b0, 32'h600D_F00D);
        smp();
        chk("wd_edge_sren", 32'(a_sren), 32'h1);
        nxt();
        a_ren = '0;
        smp();
        nxt();

        // Byte-enabled write on master 1, slave busy for three cycles
        a_wen[1] = 1'b1;
        a_addr[AW +: AW] = 32'h0000_1000;
        a_wdata[DW +: DW] = 32'h1234_5678;
        a_be[BW +: BW] = 4'b0011;
        a_sbusy = 1'b1;
        a_srdata = 32'hCAFE_F00D;
        smp();
        nxt();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                a_sbusy = 1'b0;
                push_exp(1, 1'b0, 32'hCAFE_F00D);
            end
            smp();
            chk($sformatf("wr_swen_c%0d", c), 32'(a_swen), 32'h1);
            chk($sformatf("wr_sren_c%0d", c), 32'(a_sren), 32'h0);
            chk($sformatf("wr_wdata_c%0d", c), a_swdata, 32'h1234_5678);
            chk($sformatf("wr_be_c%0d", c), 32'(a_sbe), 32'h3);
            chk($sformatf("wr_addr_c%0d", c), a_saddr, 32'h0000_1000);
            nxt();
        end
        a_wen = '0;
        smp();
        nxt();

        // Reset during a stalled grant
        a_ren[0] = 1'b1;
        a_addr[0 +: AW] = 32'h0000_3000;
        a_sbusy = 1'b1;
        smp();
        nxt();
        smp();
        chk("rstg_pre_sren", 32'(a_sren), 32'h1);
        nxt();
        RST = 1'b1;
        smp();
        nxt();
        RST = 1'b0;
        a_ren = '0;
        smp();
        chk("rstg_sren", 32'(a_sren), 32'h0);
        chk("rstg_busy", 32'(a_busy), 32'h7);
        chk("rstg_gv", 32'(a_gv), 32'h0);
        chk("rstg_err", 32'(a_err), 32'h0);
        nxt();

        // Withdrawn request mid-grant
        a_ren[0] = 1'b1;
        a_sbusy = 1'b1;
        smp();
        nxt();
        smp();
        chk("wdr_sren_on", 32'(a_sren), 32'h1);
        nxt();
        a_ren = '0;
        smp();
        chk("wdr_sren_off", 32'(a_sren), 32'h0);
        chk("wdr_gv_hold", 32'(a_gv), 32'h1);
        nxt();
        smp();
        chk("wdr_idle", 32'(a_gv), 32'h0);
        nxt();

        // Fixed priority: masters 1 and 2 compete, 1 always wins
        b_ren = 3'b110;
        b_sbusy = 1'b0;
        b_srdata = 32'h0BAD_CAFE;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk($sformatf("fp_idle_gv%0d", k), 32'(b_gv), 32'h0);
            chk($sformatf("fp_idle_busy%0d", k), 32'(b_busy), 32'h7);
            nxt();
            smp();
            chk($sformatf("fp_gi%0d", k), 32'(b_gi), 32'h1);
            chk($sformatf("fp_busy%0d", k), 32'(b_busy), 32'h5);
            chk($sformatf("fp_rdata%0d", k), b_rdata, 32'h0BAD_CAFE);
            nxt();
        end
        b_ren = '0;
        smp();
        nxt();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
